prbs31_checker: RTL

// - Receive-side partner of the PRBS31 generator (x^31 + x^28 + 1; new bit = s[27]^s[30]; serial out = s[30]).
// - Self-synchronises to the incoming serial stream and declares lock.
// - After lock, compares every received bit against a locally regenerated sequence.
// - Reports bit errors, error/bit counts and loss of lock; sits on the loopback/receive path of the test chip.

---
 rtl/prbs_pkg.sv | 18 +
 rtl/prbs31_lfsr.sv | 24 ++
 rtl/prbs31_checker.sv | 127 ++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS31 constants, FSM encodings and feedback helper shared by generator and checker
package prbs_pkg;

  localparam int PRBS31_LEN   = 31;
  localparam int PRBS31_TAP_A = 27;
  localparam int PRBS31_TAP_B = 30;

  typedef enum logic [1:0] {
    ST_SEED   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } prbs_state_t;

  function automatic logic prbs31_fb(input logic [PRBS31_LEN-1:0] s);
    return s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_lfsr.sv
// rtl/prbs31_lfsr.sv - 31-bit PRBS31 register, shifts in an external bit or its own feedback
module prbs31_lfsr
  import prbs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_ext,
  input  logic                  load_bit,
  output logic [PRBS31_LEN-1:0] state,
  output logic                  exp_bit
);

  assign exp_bit = prbs31_fb(state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= '0;
    end else if (en) begin
      state <= {state[PRBS31_LEN-2:0], (load_ext ? load_bit : exp_bit)};
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS31 receive checker: self-seed, lock, bit error and loss-of-lock reporting
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESH = 64,
  parameter int WINDOW      = 256,
  parameter int LOS_ERRS    = 8,
  parameter int ERR_CNT_W   = 16,
  parameter int BIT_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic [1:0]           state_dbg
);

  localparam int SEED_W = $clog2(PRBS31_LEN);
  localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(LOS_ERRS + 1);

  prbs_state_t               state;
  logic [PRBS31_LEN-1:0]     lfsr;
  logic                      exp_bit;
  logic                      seeding;
  logic                      mismatch;
  logic                      chk_bit;
  logic                      err_bit;
  logic [SEED_W-1:0]         seed_cnt;
  logic [GOOD_W-1:0]         good_cnt;
  logic [WIN_W-1:0]          win_cnt;
  logic [WERR_W-1:0]         win_err;

  // The unused encoding 11 behaves as SEED, so it also shifts in received bits.
  assign seeding  = (state != ST_SYNC) && (state != ST_LOCKED);
  assign mismatch = bit_in ^ exp_bit;
  assign chk_bit  = bit_valid && (state == ST_LOCKED);
  assign err_bit  = chk_bit && mismatch;

  assign locked    = (state == ST_LOCKED);
  assign state_dbg = state;

  prbs31_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bit_valid),
    .load_ext (seeding),
    .load_bit (bit_in),
    .state    (lfsr),
    .exp_bit  (exp_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SEED;
      seed_cnt  <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= err_bit;

      // Clear wins over a coincident increment; counts stick at all-ones.
      if (clear_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end else begin
        if (err_bit && (err_count != '1)) err_count <= err_count + 1'b1;
        if (chk_bit && (bit_count != '1)) bit_count <= bit_count + 1'b1;
      end

      if (bit_valid) begin
        case (state)
          ST_SYNC: begin
            if (mismatch) begin
              state    <= ST_SEED;
              seed_cnt <= '0;
              good_cnt <= '0;
            end else if (good_cnt == GOOD_W'(LOCK_THRESH - 1)) begin
              state    <= ST_LOCKED;
              good_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (mismatch && (win_err == WERR_W'(LOS_ERRS - 1))) begin
              state    <= ST_SEED;
              seed_cnt <= '0;
              good_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              if (mismatch) win_err <= win_err + 1'b1;
            end
          end
          default: begin
            state <= ST_SEED;
            if (seed_cnt == SEED_W'(PRBS31_LEN - 1)) begin
              seed_cnt <= '0;
              // An all-zero seed is the LFSR lock-up state; never sync on it.
              if ((lfsr[PRBS31_LEN-2:0] != '0) || bit_in) state <= ST_SYNC;
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
